// File: rtl/rvga_mem_arbiter.sv
// Merges the instruction-fetch and data ports onto one word-wide DDR request channel.
// Sub-word data writes run as read, merge, then full-word write.
module rvga_mem_arbiter #(
  parameter logic ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] ddr_addr,
  output logic        ddr_read,
  output logic        ddr_write,
  output logic [31:0] ddr_wdata,
  input  logic [31:0] ddr_rdata,
  input  logic        ddr_resp
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic        last_d;
  logic        gnt_d;
  logic        op_wr;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        d_req;
  logic        pick_d;
  logic        sel_wr;
  logic [31:0] sel_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Tie-break: round-robin favours the port not served last; fixed mode favours data.
  always_comb begin
    d_req  = d_read | d_write;
    pick_d = d_req;
    if (d_req && i_read) pick_d = ROUND_ROBIN ? ~last_d : 1'b1;
    sel_wr   = pick_d & d_write;
    sel_addr = pick_d ? d_addr : i_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      gnt_d     <= 1'b0;
      op_wr     <= 1'b0;
      ddr_addr  <= 32'h0;
      ddr_read  <= 1'b0;
      ddr_write <= 1'b0;
      ddr_wdata <= 32'h0;
      i_resp    <= 1'b0;
      d_resp    <= 1'b0;
      i_rdata   <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (i_read || d_req) begin
            gnt_d    <= pick_d;
            op_wr    <= sel_wr;
            ddr_addr <= sel_addr & 32'hFFFF_FFFC;
            if (!sel_wr) begin
              state    <= RD;
              ddr_read <= 1'b1;
            end else if (d_wmask == 4'hF) begin
              state     <= WR;
              ddr_write <= 1'b1;
              ddr_wdata <= d_wdata;
            end else if (d_wmask == 4'h0) begin
              state <= DONE;
            end else begin
              state    <= RD;
              ddr_read <= 1'b1;
            end
          end
        end
        RD: begin
          if (ddr_resp) begin
            ddr_read <= 1'b0;
            state    <= op_wr ? MERGE : DONE;
          end
        end
        // Strobe-free cycle; doubles as the idle gap before the write.
        MERGE: begin
          ddr_wdata <= merge_bytes(rdata_q, wdata_q, mask_q);
          ddr_write <= 1'b1;
          state     <= WR;
        end
        WR: begin
          if (ddr_resp) begin
            ddr_write <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (gnt_d) begin
            d_resp  <= 1'b1;
            d_rdata <= rdata_q;
          end else begin
            i_resp  <= 1'b1;
            i_rdata <= rdata_q;
          end
          last_d <= gnt_d;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath captures carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      mask_q  <= d_wmask;
      wdata_q <= d_wdata;
    end
    if (state == RD && ddr_resp) rdata_q <= ddr_rdata;
  end

endmodule
